// File: rtl/dht_pkg_060.sv
// Shared definitions for the DHT11 receiver: FSM state codes, frame layout,
// and the mapping from frame bytes to the four displayed digit pairs.
package dht_pkg_060;

    // FSM state codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_REL    = 3'd2;
    localparam logic [2:0] ST_RESP_L = 3'd3;
    localparam logic [2:0] ST_RESP_H = 3'd4;
    localparam logic [2:0] ST_BIT_L  = 3'd5;
    localparam logic [2:0] ST_BIT_H  = 3'd6;
    localparam logic [2:0] ST_CHECK  = 3'd7;

    // Frame is received MSB first: HI is the top byte, CS the bottom byte
    localparam int FRAME_W = 40;
    localparam logic [2:0] BYTE_HI = 3'd4;
    localparam logic [2:0] BYTE_HD = 3'd3;
    localparam logic [2:0] BYTE_TI = 3'd2;
    localparam logic [2:0] BYTE_TD = 3'd1;
    localparam logic [2:0] BYTE_CS = 3'd0;

    // Digit pair p (num[2p+1], num[2p+2]) shows frame byte PAIR_BYTE[p]
    localparam logic [3:0][2:0] PAIR_BYTE = {BYTE_TD, BYTE_TI, BYTE_HD, BYTE_HI};

    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f, input logic [2:0] idx);
        return f[int'(idx)*8 +: 8];
    endfunction

    // Checksum is the low 8 bits of the sum of the four data bytes
    function automatic logic sum_ok(input logic [FRAME_W-1:0] f);
        logic [7:0] s;
        s = frame_byte(f, BYTE_HI) + frame_byte(f, BYTE_HD)
          + frame_byte(f, BYTE_TI) + frame_byte(f, BYTE_TD);
        return s == frame_byte(f, BYTE_CS);
    endfunction

endpackage

// File: rtl/bin2bcd99_060.sv
// Byte to two BCD digits; values above 99 are shown as 99.
module bin2bcd99_060 (
    input  logic [7:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);
    logic [7:0] v;

    // clamp then split into tens and units
    always_comb begin
        v     = (bin > 8'd99) ? 8'd99 : bin;
        tens  = 4'(v / 8'd10);
        units = 4'(v % 8'd10);
    end
endmodule

// File: rtl/dht11_rx_060.sv
// DHT11 single-wire receiver: periodically issues a start pulse, times the
// sensor's response and 40 data bits in microseconds, validates the checksum
// and presents humidity/temperature as eight BCD digits.
module dht11_rx_060
    import dht_pkg_060::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int PERIOD_MS  = 2000,
    parameter int START_MS   = 20,
    parameter int TIMEOUT_US = 200,
    parameter int BIT1_US    = 40
) (
    input  logic       I_clk,
    input  logic       I_rst,
    inout  wire        I_O_sda,
    output logic [3:0] O_num1,
    output logic [3:0] O_num2,
    output logic [3:0] O_num3,
    output logic [3:0] O_num4,
    output logic [3:0] O_num5,
    output logic [3:0] O_num6,
    output logic [3:0] O_num7,
    output logic [3:0] O_num8,
    output logic       O_valid,
    output logic       O_err
);
    localparam int DIV       = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PERIOD_US = PERIOD_MS * 1000;
    localparam int START_US  = START_MS * 1000;
    localparam int PH_MAX_A  = (START_US > TIMEOUT_US) ? START_US : TIMEOUT_US;
    localparam int PH_MAX    = (PH_MAX_A > BIT1_US) ? PH_MAX_A : BIT1_US;
    localparam int PH_W      = $clog2(PH_MAX + 1);
    localparam int PER_W     = $clog2(PERIOD_US + 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               sda_m, sda_s, sda_d;
    logic               fall, rise;
    logic [2:0]         state, state_nxt;
    logic [PH_W-1:0]    phase_cnt;
    logic [PER_W-1:0]   period_cnt;
    logic               first;
    logic [5:0]         bit_cnt;
    logic [FRAME_W-1:0] shift_reg;
    logic [3:0][3:0]    tens_q, units_q;
    logic [3:0][7:0]    pair_bin;
    logic [3:0][3:0]    bcd_t, bcd_u;
    logic               timeout, wait_st, bit_val, last_bit;

    assign tick     = (div_cnt == DIV_W'(DIV - 1));
    assign fall     = sda_d & ~sda_s;
    assign rise     = ~sda_d & sda_s;
    assign timeout  = (phase_cnt >= PH_W'(TIMEOUT_US));
    assign wait_st  = state inside {ST_REL, ST_RESP_L, ST_RESP_H, ST_BIT_L, ST_BIT_H};
    // phase_cnt trails the true high time by one tick, so ">=" here is "high time > BIT1_US"
    assign bit_val  = (phase_cnt >= PH_W'(BIT1_US));
    assign last_bit = (bit_cnt == 6'(FRAME_W - 1));

    // Open-drain: only ever pull low, and let go the instant reset rises
    assign I_O_sda = (state == ST_START && !I_rst) ? 1'b0 : 1'bz;

    assign O_num1 = tens_q[0];
    assign O_num2 = units_q[0];
    assign O_num3 = tens_q[1];
    assign O_num4 = units_q[1];
    assign O_num5 = tens_q[2];
    assign O_num6 = units_q[2];
    assign O_num7 = tens_q[3];
    assign O_num8 = units_q[3];

    for (genvar g = 0; g < 4; g++) begin : g_bcd
        assign pair_bin[g] = frame_byte(shift_reg, PAIR_BYTE[g]);
        bin2bcd99_060 u_bcd (.bin(pair_bin[g]), .tens(bcd_t[g]), .units(bcd_u[g]));
    end

    // free-running 1 us tick
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) {sda_d, sda_s, sda_m} <= 3'b111;
        else       {sda_d, sda_s, sda_m} <= {sda_s, sda_m, I_O_sda};
    end

    // next-state: edges advance the handshake, timeout aborts any bus wait
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (tick && (first || period_cnt >= PER_W'(PERIOD_US - 1))) state_nxt = ST_START;
            ST_START:  if (tick && phase_cnt >= PH_W'(START_US - 1)) state_nxt = ST_REL;
            ST_REL:    if (timeout) state_nxt = ST_IDLE; else if (fall) state_nxt = ST_RESP_L;
            ST_RESP_L: if (timeout) state_nxt = ST_IDLE; else if (rise) state_nxt = ST_RESP_H;
            ST_RESP_H: if (timeout) state_nxt = ST_IDLE; else if (fall) state_nxt = ST_BIT_L;
            ST_BIT_L:  if (timeout) state_nxt = ST_IDLE; else if (rise) state_nxt = ST_BIT_H;
            ST_BIT_H:  if (timeout) state_nxt = ST_IDLE;
                       else if (fall) state_nxt = last_bit ? ST_CHECK : ST_BIT_L;
            ST_CHECK:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // state register, per-phase timer and start-to-start period timer
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            period_cnt <= '0;
            first      <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)               phase_cnt <= '0;
            else if (tick && phase_cnt != '1)     phase_cnt <= phase_cnt + 1'b1;
            if (state == ST_IDLE && state_nxt == ST_START) begin
                period_cnt <= '0;
                first      <= 1'b0;
            end else if (tick && period_cnt != '1) begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

    // bit capture, checksum verdict, digit update and error flag
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            tens_q    <= '0;
            units_q   <= '0;
            O_valid   <= 1'b0;
            O_err     <= 1'b0;
        end else begin
            O_valid <= 1'b0;
            if (state == ST_START) bit_cnt <= '0;
            if (state == ST_BIT_H && !timeout && fall) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], bit_val};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (wait_st && timeout) O_err <= 1'b1;
            if (state == ST_CHECK) begin
                if (sum_ok(shift_reg)) begin
                    tens_q  <= bcd_t;
                    units_q <= bcd_u;
                    O_valid <= 1'b1;
                    O_err   <= 1'b0;
                end else begin
                    O_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dht11_rx_060.sv
// Bench for dht11_rx_060: a behavioural sensor answers each start pulse;
// expected digits are queued per good frame and compared on each O_valid.
`timescale 1ns/1ps
module tb_dht11_rx_060;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       model_low = 1'b0;
    wire        sda;
    logic [3:0] n1, n2, n3, n4, n5, n6, n7, n8;
    logic       valid, err;
    wire [31:0] digits = {n1, n2, n3, n4, n5, n6, n7, n8};

    int          checks = 0;
    int          errors = 0;
    int          valid_cnt = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_digits = '0;
    longint      t_last = 0, t_prev = 0;

    assign sda = model_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    dht11_rx_060 #(
        .CLK_HZ(1000000), .PERIOD_MS(5), .START_MS(1), .TIMEOUT_US(200), .BIT1_US(40)
    ) dut (
        .I_clk(clk), .I_rst(rst), .I_O_sda(sda),
        .O_num1(n1), .O_num2(n2), .O_num3(n3), .O_num4(n4),
        .O_num5(n5), .O_num6(n6), .O_num7(n7), .O_num8(n8),
        .O_valid(valid), .O_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every O_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && valid) begin
            valid_cnt++;
            chk("sb_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("valid_digits", digits, e);
                chk("valid_err", 32'(err), 0);
            end
        end
    end

    // wait for the DUT to pull the bus low, then measure the start-pulse length
    task automatic wait_start(output int low_len);
        int n;
        n = 0;
        low_len = 0;
        while (sda !== 1'b0 && n < 8000) begin @(negedge clk); n++; end
        chk("start_seen", 32'(n < 8000), 1);
        t_prev = t_last;
        t_last = $time;
        while (sda === 1'b0 && low_len < 3000) begin @(negedge clk); low_len++; end
    endtask

    // sensor reply: response low/high, 40 bits MSB first, trailing low
    task automatic drive_frame(input logic [39:0] f, input int ovr_idx, input int ovr_high);
        int h;
        repeat (20) @(negedge clk);
        model_low = 1'b1; repeat (80) @(negedge clk);
        model_low = 1'b0; repeat (80) @(negedge clk);
        for (int i = 39; i >= 0; i--) begin
            h = f[i] ? 50 : 15;
            if (i == ovr_idx) h = ovr_high;
            model_low = 1'b1; repeat (20) @(negedge clk);
            model_low = 1'b0; repeat (h) @(negedge clk);
        end
        model_low = 1'b1; repeat (20) @(negedge clk);
        model_low = 1'b0;
    endtask

    task automatic good_frame(input string tag, input logic [39:0] f, input int oi, input int oh,
                              input logic [31:0] exp_digits);
        int len, v0;
        wait_start(len);
        chk({tag, "_start_len"}, 32'(len), 1000);
        v0 = valid_cnt;
        sb_q.push_back(exp_digits);
        drive_frame(f, oi, oh);
        repeat (10) @(negedge clk);
        chk({tag, "_valid_pulses"}, 32'(valid_cnt - v0), 1);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_digits_held"}, digits, exp_digits);
        sb_q.delete();
        last_digits = exp_digits;
    endtask

    task automatic bad_frame(input string tag, input logic [39:0] f);
        int len, v0;
        wait_start(len);
        v0 = valid_cnt;
        drive_frame(f, -1, 0);
        repeat (10) @(negedge clk);
        chk({tag, "_no_valid"}, 32'(valid_cnt - v0), 0);
        chk({tag, "_err"}, 32'(err), 1);
        chk({tag, "_digits_kept"}, digits, last_digits);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, n;
        longint t_rel;

        repeat (3) @(negedge clk);
        chk("rst_digits", digits, 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sda", 32'(sda), 1);
        rst = 1'b0;

        good_frame("good45", {8'd45, 8'd0, 8'd23, 8'd6, 8'd74}, -1, 0, 32'h45002306);
        bad_frame("bad_cs", {8'd45, 8'd0, 8'd23, 8'd6, 8'd75});
        good_frame("clamp150", {8'd150, 8'd0, 8'd0, 8'd0, 8'd150}, -1, 0, 32'h99000000);

        // silent sensor: error within TIMEOUT_US+2 of release, cadence unchanged
        wait_start(len);
        n = 0;
        while (err !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("silent_err", 32'(err), 1);
        chk("silent_err_bound", 32'(n <= 202), 1);
        chk("silent_digits_kept", digits, last_digits);

        // MSB of HI high for exactly 40 us must read as 0
        good_frame("hi40", {8'd1, 8'd2, 8'd3, 8'd4, 8'd10}, 39, 40, 32'h01020304);
        chk("period_after_silent", 32'((t_last - t_prev) / 10), 5000);
        // MSB of TD high for 41 us must read as 1 (TD=132 clamps to 99)
        good_frame("hi41", {8'd1, 8'd2, 8'd3, 8'd132, 8'd138}, 15, 41, 32'h01020399);

        // reset in the middle of START
        n = 0;
        while (sda !== 1'b0 && n < 8000) begin @(negedge clk); n++; end
        chk("rst_start_seen", 32'(n < 8000), 1);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_sda", 32'(sda), 1);
        chk("midrst_digits", digits, 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_err", 32'(err), 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        t_rel = $time;
        good_frame("post_rst", {8'd45, 8'd0, 8'd23, 8'd6, 8'd74}, -1, 0, 32'h45002306);
        chk("restart_prompt", 32'((t_last - t_rel) <= 50), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
